// File: rtl/spi_slave_port_if.sv
// CPU register-port bundle for spi_slave_port: strobes and write data in,
// registered read data and interrupt out (both valid 1 clk after the strobe).
interface spi_slave_port_if;
  logic        spi_select;
  logic [2:0]  mem_addr;
  logic        read_n;
  logic        write_n;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        irq;

  modport master (
    output spi_select, mem_addr, read_n, write_n, data_from_cpu,
    input  data_to_cpu, irq
  );
  modport slave (
    input  spi_select, mem_addr, read_n, write_n, data_from_cpu,
    output data_to_cpu, irq
  );
endinterface

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave with CPU register port; SCLK/SS_n/MOSI oversampled in clk.
// Read data and irq are registered (1 clk); TX holding register is one word deep.
module spi_slave_port #(
  parameter int                  DATABITS = 8,
  parameter bit                  LSBFIRST = 1'b0,
  parameter logic [DATABITS-1:0] FILL     = DATABITS'(8'hFF)
) (
  input  logic            clk,
  input  logic            reset_n,
  spi_slave_port_if.slave bus,
  input  logic            SCLK,
  input  logic            SS_n,
  input  logic            MOSI,
  output logic            MISO,
  output logic            MISO_oe
);
  localparam int CW = $clog2(DATABITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;
  state_t r_state, w_next;

  logic [1:0]          r_sclk_s, r_ss_s, r_mosi_s;
  logic                r_sclk_h, r_ss_h, r_mosi_h;
  logic                r_rd_d, r_wr_d;
  logic [DATABITS-1:0] r_shift, r_rx, r_rxdata, r_tx_hold;
  logic [CW-1:0]       r_bitcnt;
  logic                r_reload, r_tx_primed;
  logic                r_rrdy, r_tur, r_toe, r_roe;
  logic [5:0]          r_ctrl;
  logic [15:0]         r_data_to_cpu;
  logic                r_irq;

  logic                w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
  logic                w_rd, w_wr, w_rd_rx, w_wr_tx, w_wr_st, w_wr_ctl;
  logic                w_load, w_consume, w_tx_accept, w_word_done, w_shift_rise, w_shift_fall;
  logic [DATABITS-1:0] w_load_word, w_rx_next;
  logic [5:0]          w_flags;
  logic                w_unused;

  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_h;
  assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_h;
  assign w_ss_fall   = ~r_ss_s[1] & r_ss_h;
  assign w_ss_rise   = r_ss_s[1] & ~r_ss_h;

  assign w_rd     = bus.spi_select & ~bus.read_n & ~r_rd_d;
  assign w_wr     = bus.spi_select & ~bus.write_n & ~r_wr_d;
  assign w_rd_rx  = w_rd & (bus.mem_addr == 3'd0);
  assign w_wr_tx  = w_wr & (bus.mem_addr == 3'd1);
  assign w_wr_st  = w_wr & (bus.mem_addr == 3'd2);
  assign w_wr_ctl = w_wr & (bus.mem_addr == 3'd3);
  assign w_unused = ^bus.data_from_cpu;

  // A word reload happens either in LOAD or on the first SCLK fall after a completed word.
  assign w_shift_rise = (r_state == S_SHIFT) & w_sclk_rise & ~w_ss_rise;
  assign w_shift_fall = (r_state == S_SHIFT) & w_sclk_fall & ~w_ss_rise;
  assign w_load       = ~w_ss_rise & ((r_state == S_LOAD) | (w_shift_fall & r_reload));
  assign w_consume    = w_load & r_tx_primed;
  assign w_tx_accept  = w_wr_tx & (~r_tx_primed | w_consume);
  assign w_load_word  = r_tx_primed ? r_tx_hold : FILL;
  assign w_word_done  = w_shift_rise & (r_bitcnt == CW'(DATABITS - 1));
  assign w_rx_next    = LSBFIRST ? {r_mosi_h, r_rx[DATABITS-1:1]} : {r_rx[DATABITS-2:0], r_mosi_h};
  assign w_flags      = {r_tur | r_toe | r_roe, r_rrdy, ~r_tx_primed, r_tur, r_toe, r_roe};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    MISO_oe = 1'b0;
    case (r_state)
      S_IDLE:  if (w_ss_fall) w_next = S_LOAD;
      S_LOAD:  begin MISO_oe = 1'b1; w_next = S_SHIFT; end
      S_SHIFT: MISO_oe = 1'b1;
      default: w_next = S_IDLE;
    endcase
    if (w_ss_rise) w_next = S_IDLE;
  end

  always_comb begin
    MISO = 1'b0;
    if (r_state == S_LOAD)       MISO = LSBFIRST ? w_load_word[0] : w_load_word[DATABITS-1];
    else if (r_state == S_SHIFT) MISO = LSBFIRST ? r_shift[0] : r_shift[DATABITS-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_s <= 2'b00; r_sclk_h <= 1'b0;
      r_ss_s   <= 2'b11; r_ss_h   <= 1'b1;
      r_mosi_s <= 2'b00; r_mosi_h <= 1'b0;
      r_rd_d   <= 1'b0;  r_wr_d   <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[0], SCLK}; r_sclk_h <= r_sclk_s[1];
      r_ss_s   <= {r_ss_s[0], SS_n};   r_ss_h   <= r_ss_s[1];
      r_mosi_s <= {r_mosi_s[0], MOSI}; r_mosi_h <= r_mosi_s[1];
      r_rd_d   <= bus.spi_select & ~bus.read_n;
      r_wr_d   <= bus.spi_select & ~bus.write_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift  <= '0; r_rx <= '0; r_rxdata <= '0;
      r_bitcnt <= '0; r_reload <= 1'b0;
    end else begin
      if (w_load) begin
        r_shift  <= w_load_word;
        r_bitcnt <= '0;
        r_reload <= 1'b0;
      end else if (w_shift_fall) begin
        r_shift <= LSBFIRST ? {1'b0, r_shift[DATABITS-1:1]} : {r_shift[DATABITS-2:0], 1'b0};
      end
      if (w_shift_rise) begin
        r_rx <= w_rx_next;
        if (w_word_done) begin
          r_rxdata <= w_rx_next;
          r_bitcnt <= '0;
          r_reload <= 1'b1;
        end else begin
          r_bitcnt <= r_bitcnt + CW'(1);
        end
      end
      if (w_ss_rise) begin
        r_bitcnt <= '0;
        r_reload <= 1'b0;
      end
    end
  end

  // Flag sets take priority over CPU clears landing in the same clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_hold <= '0; r_tx_primed <= 1'b0;
      r_rrdy <= 1'b0; r_tur <= 1'b0; r_toe <= 1'b0; r_roe <= 1'b0;
      r_ctrl <= '0; r_data_to_cpu <= '0; r_irq <= 1'b0;
    end else begin
      if (w_tx_accept) begin
        r_tx_hold   <= bus.data_from_cpu[DATABITS-1:0];
        r_tx_primed <= 1'b1;
      end else if (w_consume) begin
        r_tx_primed <= 1'b0;
      end
      if (w_word_done)  r_rrdy <= 1'b1;
      else if (w_rd_rx) r_rrdy <= 1'b0;
      if (w_load & ~r_tx_primed)        r_tur <= 1'b1;
      else if (w_wr_st)                 r_tur <= 1'b0;
      if (w_wr_tx & ~w_tx_accept)       r_toe <= 1'b1;
      else if (w_wr_st)                 r_toe <= 1'b0;
      if (w_word_done & r_rrdy & ~w_rd_rx) r_roe <= 1'b1;
      else if (w_wr_st)                 r_roe <= 1'b0;
      if (w_wr_ctl) r_ctrl <= bus.data_from_cpu[8:3];
      if (w_rd) begin
        case (bus.mem_addr)
          3'd0:    r_data_to_cpu <= 16'(r_rxdata);
          3'd2:    r_data_to_cpu <= {7'd0, w_flags, 3'd0};
          3'd3:    r_data_to_cpu <= {7'd0, r_ctrl, 3'd0};
          default: r_data_to_cpu <= '0;
        endcase
      end
      r_irq <= |(w_flags & r_ctrl);
    end
  end

  assign bus.data_to_cpu = r_data_to_cpu;
  assign bus.irq         = r_irq;
endmodule
